data_ram_arbiter: RTL and testbench

Shares the single-port 128x8 data RAM between the CPU core's data path (the CPU requester, "c") and the host/debug port (the host requester, "h").
- Grants at most one access per clock.
- Supports locked read-modify-write sequences (BCF/BSF style) and returns read data with fixed latency.
- With the guard compiled in, a starvation counter keeps the host from being locked out by a continuously requesting CPU.
- Sits between both requesters and the RAM macro, replacing the direct CPU-to-RAM connection.

---
 rtl/data_ram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_data_ram_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Arbiter sharing the single-port 128x8 data RAM between the CPU data path and the host/debug port.
// Optional host starvation guard (h_wait counter, WAIT_MAX promotion): define ARB_STARVE_GUARD_EN.
module data_ram_arbiter #(
    parameter int WAIT_MAX = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c_req,
    input  logic       c_we,
    input  logic       c_lock,
    input  logic [6:0] c_addr,
    input  logic [7:0] c_wdata,
    input  logic       h_req,
    input  logic       h_we,
    input  logic       h_lock,
    input  logic [6:0] h_addr,
    input  logic [7:0] h_wdata,
    output logic       c_gnt,
    output logic       h_gnt,
    output logic       c_rvalid,
    output logic       h_rvalid,
    output logic [7:0] c_rdata,
    output logic [7:0] h_rdata,
    output logic [6:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       ram_en,
    input  logic [7:0] ram_q,
    output logic [1:0] owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_C = 2'd1,
        LOCK_H = 2'd2
    } state_t;

    if (WAIT_MAX < 1 || WAIT_MAX > 255 || LOCK_MAX < 1 || LOCK_MAX > 15) begin : g_bad_param
        $error("data_ram_arbiter: WAIT_MAX must be 1..255 and LOCK_MAX 1..15");
    end

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_lock_cnt;
    logic [3:0] w_next_cnt;
    logic       r_force_h;
    logic       r_c_rvalid;
    logic       r_h_rvalid;
    logic       w_cnt_done;
    logic       w_host_pri;
    logic       w_c_gnt;
    logic       w_h_gnt;

    assign w_cnt_done = (r_lock_cnt == 4'(LOCK_MAX - 1));

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] r_h_wait;

    // Clears on grant or as soon as the host withdraws its request.
    always_ff @(posedge clk) begin
        if (rst || !h_req || w_h_gnt)
            r_h_wait <= '0;
        else if (r_h_wait != 8'(WAIT_MAX))
            r_h_wait <= r_h_wait + 8'd1;
    end

    assign w_host_pri = r_force_h || (r_h_wait == 8'(WAIT_MAX));
`else
    assign w_host_pri = r_force_h;
`endif

    // State register; r_force_h marks the IDLE cycle right after a forced CPU lock release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lock_cnt <= '0;
            r_force_h  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_lock_cnt <= w_next_cnt;
            r_force_h  <= (r_state == LOCK_C) && w_cnt_done;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_lock_cnt;
        case (r_state)
            IDLE: begin
                w_next_cnt = '0;
                if (w_c_gnt && c_lock)
                    w_next_state = LOCK_C;
                else if (w_h_gnt && h_lock)
                    w_next_state = LOCK_H;
            end
            LOCK_C: begin
                if (w_cnt_done || (w_c_gnt && !c_lock)) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_lock_cnt + 4'd1;
                end
            end
            LOCK_H: begin
                if (w_cnt_done || (w_h_gnt && !h_lock)) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_lock_cnt + 4'd1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Grants are suppressed while rst is high so nothing reaches the RAM during reset.
    always_comb begin
        w_c_gnt = 1'b0;
        w_h_gnt = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (c_req && h_req) begin
                        w_h_gnt = w_host_pri;
                        w_c_gnt = !w_host_pri;
                    end else begin
                        w_c_gnt = c_req;
                        w_h_gnt = h_req;
                    end
                end
                LOCK_C:  w_c_gnt = c_req;
                LOCK_H:  w_h_gnt = h_req;
                default: ;
            endcase
        end
    end

    assign c_gnt    = w_c_gnt;
    assign h_gnt    = w_h_gnt;
    assign ram_en   = (w_c_gnt && c_we) || (w_h_gnt && h_we);
    assign ram_addr = w_h_gnt ? h_addr : c_addr;
    assign ram_data = w_h_gnt ? h_wdata : c_wdata;
    assign owner    = r_state;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_rvalid <= 1'b0;
            r_h_rvalid <= 1'b0;
        end else begin
            r_c_rvalid <= w_c_gnt && !c_we;
            r_h_rvalid <= w_h_gnt && !h_we;
        end
    end

    // A read granted just before reset must not surface while rst is held.
    assign c_rvalid = r_c_rvalid && !rst;
    assign h_rvalid = r_h_rvalid && !rst;
    assign c_rdata  = c_rvalid ? ram_q : '0;
    assign h_rdata  = h_rvalid ? ram_q : '0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed vector table, contention run, randomized run vs reference model.
// Follows ARB_STARVE_GUARD_EN the same way the design does.
module tb_data_ram_arbiter;

    localparam int WAIT_MAX = 8;
    localparam int LOCK_MAX = 4;

    typedef struct {
        logic       rst;
        logic       c_req, c_we, c_lock;
        logic [6:0] c_addr;
        logic [7:0] c_wdata;
        logic       h_req, h_we, h_lock;
        logic [6:0] h_addr;
        logic [7:0] h_wdata;
        logic       e_cg, e_hg, e_en, e_crv;
        logic [7:0] e_crd;
        logic       e_hrv;
        logic [7:0] e_hrd;
        logic [1:0] e_own;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       c_req, c_we, c_lock, h_req, h_we, h_lock;
    logic [6:0] c_addr, h_addr;
    logic [7:0] c_wdata, h_wdata;
    logic       c_gnt, h_gnt, c_rvalid, h_rvalid, ram_en;
    logic [7:0] c_rdata, h_rdata, ram_data, ram_q;
    logic [6:0] ram_addr;
    logic [1:0] owner;

    logic [7:0] ram_mem [128];
    logic       ram_clear;

    int         n_vectors = 0;
    int         n_miscompares = 0;

    // Reference model state
    int         m_owner, m_cnt, m_wait;
    bit         m_force_h, m_rv_c, m_rv_h;
    logic [7:0] m_rd_c, m_rd_h;
    logic [7:0] m_mem [128];

    vec_t       tbl[$];

    always #5 clk = ~clk;

    data_ram_arbiter #(.WAIT_MAX(WAIT_MAX), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
        .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr), .h_wdata(h_wdata),
        .c_gnt(c_gnt), .h_gnt(h_gnt), .c_rvalid(c_rvalid), .h_rvalid(h_rvalid),
        .c_rdata(c_rdata), .h_rdata(h_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_en(ram_en), .ram_q(ram_q),
        .owner(owner)
    );

    // RAM macro: synchronous write, registered read.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 128; i++) ram_mem[i] <= '0;
        end else if (ram_en) begin
            ram_mem[ram_addr] <= ram_data;
        end
        ram_q <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Which requester the rules grant this cycle, from the model's view of history.
    task automatic model_grants(output logic cg, output logic hg);
        logic host_first;
`ifdef ARB_STARVE_GUARD_EN
        host_first = m_force_h || (m_wait == WAIT_MAX);
`else
        host_first = m_force_h;
`endif
        cg = 1'b0;
        hg = 1'b0;
        if (!rst) begin
            if (m_owner == 1)       cg = c_req;
            else if (m_owner == 2)  hg = h_req;
            else if (c_req && h_req) begin
                hg = host_first;
                cg = !host_first;
            end else begin
                cg = c_req;
                hg = h_req;
            end
        end
    endtask

    task automatic model_step();
        logic cg, hg, g, l;
        model_grants(cg, hg);
        if (rst) begin
            m_owner = 0; m_cnt = 0; m_wait = 0;
            m_force_h = 1'b0; m_rv_c = 1'b0; m_rv_h = 1'b0;
        end else begin
            m_rv_c = cg && !c_we;
            m_rd_c = m_mem[c_addr];
            m_rv_h = hg && !h_we;
            m_rd_h = m_mem[h_addr];
            if (cg && c_we) m_mem[c_addr] = c_wdata;
            if (hg && h_we) m_mem[h_addr] = h_wdata;
            m_force_h = (m_owner == 1) && (m_cnt == LOCK_MAX - 1);
            if (m_owner == 0) begin
                m_cnt = 0;
                if (cg && c_lock)      m_owner = 1;
                else if (hg && h_lock) m_owner = 2;
            end else begin
                g = (m_owner == 1) ? cg : hg;
                l = (m_owner == 1) ? c_lock : h_lock;
                if (m_cnt == LOCK_MAX - 1 || (g && !l)) begin
                    m_owner = 0;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (!h_req || hg)          m_wait = 0;
            else if (m_wait < WAIT_MAX) m_wait++;
        end
    endtask

    task automatic model_check(input int idx);
        logic cg, hg;
        logic crv, hrv;
        model_grants(cg, hg);
        crv = m_rv_c && !rst;
        hrv = m_rv_h && !rst;
        check($sformatf("rnd%0d c_gnt", idx), 32'(c_gnt), 32'(cg));
        check($sformatf("rnd%0d h_gnt", idx), 32'(h_gnt), 32'(hg));
        check($sformatf("rnd%0d ram_en", idx), 32'(ram_en), 32'((cg && c_we) || (hg && h_we)));
        check($sformatf("rnd%0d ram_addr", idx), 32'(ram_addr), 32'(hg ? h_addr : c_addr));
        check($sformatf("rnd%0d ram_data", idx), 32'(ram_data), 32'(hg ? h_wdata : c_wdata));
        check($sformatf("rnd%0d c_rvalid", idx), 32'(c_rvalid), 32'(crv));
        check($sformatf("rnd%0d c_rdata", idx), 32'(c_rdata), 32'(crv ? m_rd_c : 8'h00));
        check($sformatf("rnd%0d h_rvalid", idx), 32'(h_rvalid), 32'(hrv));
        check($sformatf("rnd%0d h_rdata", idx), 32'(h_rdata), 32'(hrv ? m_rd_h : 8'h00));
        check($sformatf("rnd%0d owner", idx), 32'(owner), 32'(m_owner));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic add(input logic r,
                       input logic cr, input logic cw, input logic cl, input logic [6:0] ca, input logic [7:0] cd,
                       input logic hr, input logic hw, input logic hl, input logic [6:0] ha, input logic [7:0] hd,
                       input logic eg_c, input logic eg_h, input logic e_en,
                       input logic e_crv, input logic [7:0] e_crd,
                       input logic e_hrv, input logic [7:0] e_hrd, input logic [1:0] e_own);
        vec_t v;
        v.rst = r;
        v.c_req = cr; v.c_we = cw; v.c_lock = cl; v.c_addr = ca; v.c_wdata = cd;
        v.h_req = hr; v.h_we = hw; v.h_lock = hl; v.h_addr = ha; v.h_wdata = hd;
        v.e_cg = eg_c; v.e_hg = eg_h; v.e_en = e_en;
        v.e_crv = e_crv; v.e_crd = e_crd; v.e_hrv = e_hrv; v.e_hrd = e_hrd; v.e_own = e_own;
        tbl.push_back(v);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        rst = v.rst;
        c_req = v.c_req; c_we = v.c_we; c_lock = v.c_lock; c_addr = v.c_addr; c_wdata = v.c_wdata;
        h_req = v.h_req; h_we = v.h_we; h_lock = v.h_lock; h_addr = v.h_addr; h_wdata = v.h_wdata;
        @(negedge clk);
        check($sformatf("row%0d c_gnt", idx), 32'(c_gnt), 32'(v.e_cg));
        check($sformatf("row%0d h_gnt", idx), 32'(h_gnt), 32'(v.e_hg));
        check($sformatf("row%0d ram_en", idx), 32'(ram_en), 32'(v.e_en));
        check($sformatf("row%0d c_rvalid", idx), 32'(c_rvalid), 32'(v.e_crv));
        check($sformatf("row%0d c_rdata", idx), 32'(c_rdata), 32'(v.e_crd));
        check($sformatf("row%0d h_rvalid", idx), 32'(h_rvalid), 32'(v.e_hrv));
        check($sformatf("row%0d h_rdata", idx), 32'(h_rdata), 32'(v.e_hrd));
        check($sformatf("row%0d owner", idx), 32'(owner), 32'(v.e_own));
        tick();
    endtask

    initial begin
        rst = 1'b1; ram_clear = 1'b1;
        c_req = 0; c_we = 0; c_lock = 0; c_addr = '0; c_wdata = '0;
        h_req = 0; h_we = 0; h_lock = 0; h_addr = '0; h_wdata = '0;
        for (int i = 0; i < 128; i++) m_mem[i] = '0;
        m_owner = 0; m_cnt = 0; m_wait = 0;
        m_force_h = 1'b0; m_rv_c = 1'b0; m_rv_h = 1'b0; m_rd_c = '0; m_rd_h = '0;

        tick();
        ram_clear = 1'b0;
        tick();

        //   rst  c: req we lk addr   data   h: req we lk addr   data   | cg hg en crv crd   hrv hrd   own
        add(1,    0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        // CPU write then read-back
        add(0,    1, 1, 0, 7'h20, 8'h5A,  0, 0, 0, 7'h00, 8'h00,  1, 0, 1, 0, 8'h00, 0, 8'h00, 0);
        add(0,    1, 0, 0, 7'h20, 8'h00,  0, 0, 0, 7'h00, 8'h00,  1, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0,    0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 1, 8'h5A, 0, 8'h00, 0);
        add(0,    1, 1, 0, 7'h10, 8'h0F,  0, 0, 0, 7'h00, 8'h00,  1, 0, 1, 0, 8'h00, 0, 8'h00, 0);
        add(0,    0, 0, 0, 7'h00, 8'h00,  1, 1, 0, 7'h30, 8'hA5,  0, 1, 1, 0, 8'h00, 0, 8'h00, 0);
        // Locked RMW with host waiting
        add(0,    1, 0, 1, 7'h10, 8'h00,  1, 0, 0, 7'h30, 8'h00,  1, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0,    1, 1, 0, 7'h10, 8'h8F,  1, 0, 0, 7'h30, 8'h00,  1, 0, 1, 1, 8'h0F, 0, 8'h00, 1);
        add(0,    0, 0, 0, 7'h00, 8'h00,  1, 0, 0, 7'h30, 8'h00,  0, 1, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0,    1, 0, 0, 7'h10, 8'h00,  0, 0, 0, 7'h00, 8'h00,  1, 0, 0, 0, 8'h00, 1, 8'hA5, 0);
        add(0,    0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 1, 8'h8F, 0, 8'h00, 0);
        // Host lock timeout: entry + LOCK_MAX locked cycles, then CPU
        add(0,    0, 0, 0, 7'h00, 8'h00,  1, 0, 1, 7'h30, 8'h00,  0, 1, 0, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 0, 7'h20, 8'h00, 1, 0, 1, 7'h30, 8'h00,  0, 1, 0, 0, 8'h00, 1, 8'hA5, 2);
        add(0,    1, 0, 0, 7'h20, 8'h00,  1, 0, 1, 7'h30, 8'h00,  1, 0, 0, 0, 8'h00, 1, 8'hA5, 0);
        add(0,    0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 1, 8'h5A, 0, 8'h00, 0);
        // CPU lock timeout: host must win the IDLE cycle after the forced release
        add(0,    1, 0, 1, 7'h20, 8'h00,  1, 0, 0, 7'h30, 8'h00,  1, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 0, 1, 7'h20, 8'h00, 1, 0, 0, 7'h30, 8'h00,  1, 0, 0, 1, 8'h5A, 0, 8'h00, 1);
        add(0,    1, 0, 1, 7'h20, 8'h00,  1, 0, 0, 7'h30, 8'h00,  0, 1, 0, 1, 8'h5A, 0, 8'h00, 0);
        add(0,    0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 0, 8'h00, 1, 8'hA5, 0);
        // Reset right after a locked host read
        add(0,    0, 0, 0, 7'h00, 8'h00,  1, 0, 1, 7'h30, 8'h00,  0, 1, 0, 0, 8'h00, 0, 8'h00, 0);
        add(1,    0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 0, 8'h00, 0, 8'h00, 2);
        add(0,    0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0,    0, 0, 0, 7'h00, 8'h00,  1, 0, 0, 7'h30, 8'h00,  0, 1, 0, 0, 8'h00, 0, 8'h00, 0);
        add(0,    0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 7'h00, 8'h00,  0, 0, 0, 0, 8'h00, 1, 8'hA5, 0);

        foreach (tbl[i]) apply_vec(i, tbl[i]);

        // Continuous contention: with the guard the host gets every 9th slot, without it never.
        rst = 0;
        c_req = 1; c_we = 0; c_lock = 0; c_addr = 7'h20;
        h_req = 1; h_we = 0; h_lock = 0; h_addr = 7'h30;
        for (int i = 0; i < 18; i++) begin
            logic exp_h;
`ifdef ARB_STARVE_GUARD_EN
            exp_h = ((i % (WAIT_MAX + 1)) == WAIT_MAX);
`else
            exp_h = 1'b0;
`endif
            @(negedge clk);
            check($sformatf("contend%0d h_gnt", i), 32'(h_gnt), 32'(exp_h));
            check($sformatf("contend%0d c_gnt", i), 32'(c_gnt), 32'(!exp_h));
            tick();
        end
        c_req = 0; h_req = 0;
        tick();

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            c_req   = ($urandom_range(0, 3) != 0);
            c_we    = $urandom_range(0, 1) != 0;
            c_lock  = ($urandom_range(0, 3) == 0);
            c_addr  = 7'($urandom_range(0, 7));
            c_wdata = 8'($urandom);
            h_req   = ($urandom_range(0, 3) != 0);
            h_we    = $urandom_range(0, 1) != 0;
            h_lock  = ($urandom_range(0, 3) == 0);
            h_addr  = 7'($urandom_range(0, 7));
            h_wdata = 8'($urandom);
            @(negedge clk);
            model_check(i);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
